// File: rtl/secuencia_escritura_pkg.sv
// Shared constants and types for the address/data write sequencer.
// Modes, step counts, fixed bytes and the FSM state type live here.
package secuencia_escritura_pkg;

    localparam logic [1:0] MODO_INIT  = 2'd0;
    localparam logic [1:0] MODO_CMD   = 2'd1;
    localparam logic [1:0] MODO_HORA  = 2'd2;
    localparam logic [1:0] MODO_FECHA = 2'd3;

    localparam int PASOS_INIT  = 4;
    localparam int PASOS_CMD   = 4;
    localparam int PASOS_HORA  = 6;
    localparam int PASOS_FECHA = 6;

    localparam logic [7:0] DIR_CTRL = 8'h02;
    localparam logic [7:0] CFG_INIT = 8'h10;
    localparam logic [7:0] DIR_CMD  = 8'h16;
    localparam logic [7:0] CMD_D2   = 8'hD2;
    localparam logic [7:0] DIR_SEG  = 8'h21;
    localparam logic [7:0] DIR_MIN  = 8'h22;
    localparam logic [7:0] DIR_HOR  = 8'h23;
    localparam logic [7:0] DIR_DIA  = 8'h24;
    localparam logic [7:0] DIR_MES  = 8'h25;
    localparam logic [7:0] DIR_ANIO = 8'h26;
    localparam logic [7:0] BYTE_0   = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENVIO = 2'd1,
        FIN   = 2'd2
    } estado_t;

    function automatic int pasos_de(input logic [1:0] modo);
        int n;
        case (modo)
            MODO_INIT:  n = PASOS_INIT;
            MODO_CMD:   n = PASOS_CMD;
            MODO_HORA:  n = PASOS_HORA;
            default:    n = PASOS_FECHA;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/secuencia_escritura_tabla.sv
// Combinational sequence table: maps (modo, paso, values) to the byte
// to emit, whether it is an address, and whether it is the last step.
module secuencia_tabla
    import secuencia_escritura_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic [1:0]       modo,
    input  logic [CNT_W-1:0] paso,
    input  logic [W-1:0]     val_a,
    input  logic [W-1:0]     val_b,
    input  logic [W-1:0]     val_c,
    output logic [W-1:0]     dato,
    output logic             es_dir,
    output logic             ultimo
);

    logic [7:0]   byte_fijo;
    logic [W-1:0] val_sel;
    logic         usa_val;
    int           idx;

    always_comb begin
        idx       = int'(paso);
        byte_fijo = BYTE_0;
        val_sel   = '0;
        usa_val   = 1'b0;
        es_dir    = ~paso[0];
        ultimo    = (idx == pasos_de(modo) - 1);

        case (modo)
            MODO_INIT: begin
                case (idx)
                    0:       byte_fijo = DIR_CTRL;
                    1:       byte_fijo = CFG_INIT;
                    2:       byte_fijo = DIR_CTRL;
                    default: byte_fijo = BYTE_0;
                endcase
            end
            MODO_CMD: begin
                case (idx)
                    0:       byte_fijo = DIR_CMD;
                    2:       byte_fijo = CMD_D2;
                    default: byte_fijo = BYTE_0;
                endcase
            end
            MODO_HORA: begin
                case (idx)
                    0:       byte_fijo = DIR_SEG;
                    2:       byte_fijo = DIR_MIN;
                    4:       byte_fijo = DIR_HOR;
                    default: byte_fijo = BYTE_0;
                endcase
            end
            default: begin
                case (idx)
                    0:       byte_fijo = DIR_DIA;
                    2:       byte_fijo = DIR_MES;
                    4:       byte_fijo = DIR_ANIO;
                    default: byte_fijo = BYTE_0;
                endcase
            end
        endcase

        // Odd steps of the clock/date modes carry the captured values
        if (modo == MODO_HORA || modo == MODO_FECHA) begin
            case (idx)
                1: begin usa_val = 1'b1; val_sel = val_a; end
                3: begin usa_val = 1'b1; val_sel = val_b; end
                5: begin usa_val = 1'b1; val_sel = val_c; end
                default: begin usa_val = 1'b0; val_sel = '0; end
            endcase
        end

        dato = usa_val ? val_sel : W'(byte_fijo);
    end

endmodule

// File: rtl/secuencia_escritura.sv
// Write sequencer: on start, emits a fixed address/data byte sequence
// with a valid/ack handshake, then pulses band for one cycle.
module secuencia_escritura
    import secuencia_escritura_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int N_MAX = 8,
    localparam int CNT_W = $clog2(N_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       modo,
    input  logic [W-1:0]     val_a,
    input  logic [W-1:0]     val_b,
    input  logic [W-1:0]     val_c,
    input  logic             ack,
    input  logic             cancelar,
    output logic [W-1:0]     dato,
    output logic             valido,
    output logic             es_dir,
    output logic [CNT_W-1:0] paso,
    output logic             ocupado,
    output logic             band
);

    estado_t          estado;
    estado_t          estado_sig;
    logic [CNT_W-1:0] paso_q;
    logic [CNT_W-1:0] paso_d;
    logic             captura;

    logic [1:0]       modo_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     c_q;

    logic [W-1:0]     t_dato;
    logic             t_es_dir;
    logic             t_ultimo;

    secuencia_tabla #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_tabla (
        .modo   (modo_q),
        .paso   (paso_q),
        .val_a  (a_q),
        .val_b  (b_q),
        .val_c  (c_q),
        .dato   (t_dato),
        .es_dir (t_es_dir),
        .ultimo (t_ultimo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= IDLE;
            paso_q <= '0;
            modo_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
        end else begin
            estado <= estado_sig;
            paso_q <= paso_d;
            if (captura) begin
                modo_q <= modo;
                a_q    <= val_a;
                b_q    <= val_b;
                c_q    <= val_c;
            end
        end
    end

    // Abort wins over everything, including a pending ack
    always_comb begin
        estado_sig = estado;
        paso_d     = paso_q;
        captura    = 1'b0;
        if (cancelar) begin
            estado_sig = IDLE;
            paso_d     = '0;
        end else begin
            unique case (estado)
                IDLE: begin
                    if (start) begin
                        estado_sig = ENVIO;
                        paso_d     = '0;
                        captura    = 1'b1;
                    end
                end
                ENVIO: begin
                    if (ack) begin
                        if (t_ultimo) begin
                            estado_sig = FIN;
                            paso_d     = '0;
                        end else begin
                            paso_d = paso_q + CNT_W'(1);
                        end
                    end
                end
                FIN: begin
                    estado_sig = IDLE;
                    paso_d     = '0;
                end
                default: begin
                    estado_sig = IDLE;
                    paso_d     = '0;
                end
            endcase
        end
    end

    always_comb begin
        dato    = '0;
        valido  = 1'b0;
        es_dir  = 1'b0;
        paso    = '0;
        ocupado = 1'b0;
        band    = 1'b0;
        unique case (estado)
            ENVIO: begin
                dato    = t_dato;
                valido  = 1'b1;
                es_dir  = t_es_dir;
                paso    = paso_q;
                ocupado = 1'b1;
            end
            FIN: begin
                ocupado = 1'b1;
                band    = 1'b1;
            end
            default: begin
                dato    = '0;
                valido  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/secuencia_escritura.md
SECUENCIA_ESCRITURA -- requirements
Module: secuencia_escritura

Interface
REQ-001 Parameter W, default 8, SHALL set the width of the data bus and the captured value inputs; W>=8.
REQ-002 Parameter N_MAX, default 8, SHALL set the maximum number of steps per sequence; the step counter SHALL be CNT_W=$clog2(N_MAX+1) bits wide.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a sequence.
REQ-006 modo  in  2  sequence selector, sampled when start is accepted.
REQ-007 val_a, val_b, val_c  in  W each  values inserted into data steps (seconds/minutes/hours or day/month/year), sampled when start is accepted.
REQ-008 ack  in  1  bus-driver acknowledge of the current byte.
REQ-009 cancelar  in  1  synchronous abort.
REQ-010 dato  out  W  current address or data byte.
REQ-011 valido  out  1  dato/es_dir are valid and awaiting ack.
REQ-012 es_dir  out  1  1 = dato is an address byte, 0 = data byte.
REQ-013 paso  out  CNT_W  index of the current step.
REQ-014 ocupado  out  1  a sequence is in progress.
REQ-015 band  out  1  one-cycle pulse marking sequence completion.

Function
REQ-016 Sequence tables SHALL be fixed, with bytes zero-extended to W and steps alternating address then data; es_dir SHALL be 1 on even paso.
REQ-017 modo=0 (INIT) SHALL emit 4 steps: 02h, 10h, 02h, 00h.
REQ-018 modo=1 (CMD) SHALL emit 4 steps: 16h, 00h, D2h, 00h, preserving the legacy command sequence.
REQ-019 modo=2 (HORA) SHALL emit 6 steps: 21h, val_a, 22h, val_b, 23h, val_c.
REQ-020 modo=3 (FECHA) SHALL emit 6 steps: 24h, val_a, 25h, val_b, 26h, val_c.
REQ-021 The FSM SHALL have the states IDLE, ENVIO and FIN.
REQ-022 In IDLE, start=1 at edge k SHALL capture modo and val_a..val_c and enter ENVIO with paso=0, so that valido=1 and ocupado=1 from cycle k+1.
REQ-023 In ENVIO, valido SHALL stay high and dato/es_dir/paso SHALL stay stable until ack=1 is sampled.
REQ-024 When ack=1 is sampled on a non-final step, paso SHALL increment and the next byte SHALL be presented in the following cycle with valido still high; back-to-back acks SHALL advance one step per cycle.
REQ-025 When ack=1 is sampled on the final step, the FSM SHALL enter FIN: valido=0, band=1, ocupado=1 for exactly one cycle, then return to IDLE.
REQ-026 ack SHALL be ignored when valido=0, and start SHALL be ignored outside IDLE.
REQ-027 cancelar=1 SHALL take priority over ack: the FSM SHALL go to IDLE on the next edge with band=0 and paso=0.
REQ-028 In IDLE, dato=0, valido=0, es_dir=0, paso=0, ocupado=0 and band=0; band SHALL be 1 only in FIN.
REQ-029 Changes to modo or val_* during a sequence SHALL NOT affect the emitted bytes.

Reset
REQ-030 reset=1 SHALL asynchronously force IDLE, clear all captured registers and drive all outputs to 0, including mid-sequence, with no band pulse.
REQ-031 After reset is released, the first accepted start SHALL begin a new sequence at paso=0.

Structure
REQ-032 A shared package SHALL hold the modo encodings, the per-mode step counts, the address/command constants (02h, 10h, 16h, D2h, 21h-26h) and the FSM state type.
REQ-033 One sub-module, secuencia_tabla, SHALL be purely combinational and map (modo, paso, val_a..val_c) to (dato, es_dir, ultimo); the FSM and counter SHALL reside in secuencia_escritura.

Verification
REQ-034 The bench SHALL cover: modo=1, start, ack held high -> dato 16h, 00h, D2h, 00h on 4 consecutive cycles, then band=1 for one cycle.
REQ-035 The bench SHALL cover: modo=2, val_a=30h, val_b=45h, val_c=12h, ack asserted every third cycle -> 21h, 30h, 22h, 45h, 23h, 12h, each held stable until its ack, with es_dir=1,0,1,0,1,0.
REQ-036 The bench SHALL cover: modo=3 started, then modo and val_a changed at paso=1 -> emitted bytes equal the start-time capture.
REQ-037 The bench SHALL cover: modo=0, cancelar=1 at paso=2 -> IDLE next cycle, ocupado=0, no band; a new start restarts at 02h.
REQ-038 The bench SHALL cover: reset pulsed at paso=3 of modo=2 -> all outputs 0 immediately, with no band pulse.
REQ-039 The bench SHALL cover: start during ENVIO and ack during IDLE -> both ignored, with paso and state unchanged.
